// File: rtl/load_store_unit.sv
// load_store_unit
//    Load/store unit with one data-cache port and an in-order store buffer.
//    Loads and stores arrive on one valid/ready request port. Stores are
//    queued in a FIFO of SB_DEPTH entries. The FIFO drains into the cache
//    whenever the unit is idle and no load is waiting to go. A load bypasses
//    pending stores, unless one of them targets the same word. In that case
//    the load stalls until the matching stores have drained.
//    Only one cache access is outstanding at a time.
//
//    Build option: define LSU_STORE_FWD_EN to answer loads directly from the
//    store buffer. This happens when the youngest matching entry covers every
//    byte the load reads.
//
// Ports
//    clk_i, rst_i               clock, synchronous active-high reset
//    req_valid_i/req_ready_o    request handshake
//    req_op_i                   {is_store, unsigned, size[1:0]}
//    req_addr_i, req_wdata_i    byte address, store data (LSBs)
//    req_rd_i                   load destination label
//    resp_valid_o/rd_o/data_o   one-cycle load completion with extended data
//    misalign_o                 one-cycle pulse for a rejected misaligned request
//    sb_empty_o                 no store queued or in flight
//    data_cache_*_o             word address, byte write enables, write data, enable
//    data_cache_data_i          load data from the cache
//    data_cache_blocking_n_i    cache not busy (access completes when high)
module load_store_unit #(
   parameter int SB_DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [3:0]  req_op_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        resp_valid_o,
   output logic [4:0]  resp_rd_o,
   output logic [31:0] resp_data_o,
   output logic        misalign_o,
   output logic        sb_empty_o,
   output logic [31:2] data_cache_address_o,
   output logic [3:0]  data_cache_write_en_o,
   output logic [31:0] data_cache_data_o,
   output logic        data_cache_enabled_o,
   input  logic [31:0] data_cache_data_i,
   input  logic        data_cache_blocking_n_i
);

   localparam int PW = $clog2(SB_DEPTH);
   localparam int CW = $clog2(SB_DEPTH) + 1;
   localparam logic [CW-1:0] COUNT_FULL = CW'(SB_DEPTH);
   localparam logic [CW-1:0] COUNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      LD_ACC = 2'b01,
      ST_ACC = 2'b10
   } state_e;

   // Extract and extend the loaded byte/half/word from a 32-bit word.
   function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      case (off)
         2'b00:   b = word[7:0];
         2'b01:   b = word[15:8];
         2'b10:   b = word[23:16];
         default: b = word[31:24];
      endcase
      h = off[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   // Byte lanes touched by an access of the given size at the given offset.
   function automatic logic [3:0] byte_mask(input logic [1:0] off, input logic [1:0] size);
      logic [3:0] m;
      case (size)
         2'b00:   m = 4'b0001 << off;
         2'b01:   m = off[1] ? 4'b1100 : 4'b0011;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   // Misalignment: halves need addr[0]=0, words (and reserved size) need addr[1:0]=0.
   function automatic logic is_misaligned(input logic [1:0] off, input logic [1:0] size);
      logic r;
      case (size)
         2'b00:   r = 1'b0;
         2'b01:   r = off[0];
         default: r = (off != 2'b00);
      endcase
      return r;
   endfunction

   // State and registered outputs
   state_e         state_q, state_d;
   logic           first_q, first_d;
   logic [29:0]    cache_addr_q, cache_addr_d;
   logic [3:0]     cache_we_q, cache_we_d;
   logic [31:0]    cache_wdata_q, cache_wdata_d;
   logic           cache_en_q, cache_en_d;
   logic [1:0]     ld_off_q, ld_off_d;
   logic [1:0]     ld_size_q, ld_size_d;
   logic           ld_uns_q, ld_uns_d;
   logic [4:0]     ld_rd_q, ld_rd_d;
   logic           resp_valid_q, resp_valid_d;
   logic [4:0]     resp_rd_q, resp_rd_d;
   logic [31:0]    resp_data_q, resp_data_d;
   logic           misalign_q, misalign_d;
   logic           sb_empty_q, sb_empty_d;

   // Store buffer
   logic [29:0]    sb_addr_q [SB_DEPTH];
   logic [3:0]     sb_be_q   [SB_DEPTH];
   logic [31:0]    sb_data_q [SB_DEPTH];
   logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]  count_q, count_d;

   // Combinational helpers
   logic           req_store_s;
   logic           req_mis_s;
   logic [3:0]     st_be_s;
   logic [31:0]    st_data_s;
   logic [PW-1:0]  scan_idx_s;
   logic           hit_s;
   logic           ld_fwd_s;
   logic           ld_stall_s;
   logic           accept_s;
   logic           enq_s;
   logic           deq_s;
   logic           ld_go_s;
   logic           ld_fwd_go_s;
   logic           drain_s;
   logic           done_s;
`ifdef LSU_STORE_FWD_EN
   logic [3:0]     hit_be_s;
   logic [31:0]    hit_data_s;
   logic [3:0]     ld_be_s;
`endif

   // Request decode and the store-entry image (enables plus lane-replicated data)
   always_comb begin
      req_store_s = req_op_i[3];
      req_mis_s   = is_misaligned(req_addr_i[1:0], req_op_i[1:0]);
      st_be_s     = byte_mask(req_addr_i[1:0], req_op_i[1:0]);
      case (req_op_i[1:0])
         2'b00:   st_data_s = {4{req_wdata_i[7:0]}};
         2'b01:   st_data_s = {2{req_wdata_i[15:0]}};
         default: st_data_s = req_wdata_i;
      endcase
   end

   // Scan valid entries oldest to youngest; the last hit is the youngest match.
   // The entry being written to the cache is still counted, so it also matches.
   always_comb begin
      hit_s      = 1'b0;
      scan_idx_s = rd_ptr_q;
`ifdef LSU_STORE_FWD_EN
      hit_be_s   = 4'b0000;
      hit_data_s = 32'h0000_0000;
`endif
      for (int k = 0; k < SB_DEPTH; k++) begin
         scan_idx_s = rd_ptr_q + PW'(k);
         if ((CW'(k) < count_q) && (sb_addr_q[scan_idx_s] == req_addr_i[31:2])) begin
            hit_s      = 1'b1;
`ifdef LSU_STORE_FWD_EN
            hit_be_s   = sb_be_q[scan_idx_s];
            hit_data_s = sb_data_q[scan_idx_s];
`endif
         end else begin
            hit_s = hit_s;
         end
      end
   end

   // Decide whether a matching load is forwarded or stalled
   always_comb begin
`ifdef LSU_STORE_FWD_EN
      ld_be_s    = byte_mask(req_addr_i[1:0], req_op_i[1:0]);
      ld_fwd_s   = hit_s && ((hit_be_s & ld_be_s) == ld_be_s);
      ld_stall_s = hit_s && !ld_fwd_s;
`else
      ld_fwd_s   = 1'b0;
      ld_stall_s = hit_s;
`endif
   end

   // Ready: misaligned requests are always consumed, stores need a free slot,
   // loads need the idle state and no conflicting pending store.
   always_comb begin
      if (!req_valid_i) begin
         req_ready_o = 1'b0;
      end else if (req_mis_s) begin
         req_ready_o = 1'b1;
      end else if (req_store_s) begin
         req_ready_o = (count_q != COUNT_FULL);
      end else begin
         req_ready_o = (state_q == IDLE) && !ld_stall_s;
      end
   end

   // Handshake qualifiers and access completion
   always_comb begin
      accept_s    = req_valid_i && req_ready_o;
      enq_s       = accept_s && req_store_s && !req_mis_s;
      ld_go_s     = accept_s && !req_store_s && !req_mis_s && !ld_fwd_s;
      ld_fwd_go_s = accept_s && !req_store_s && !req_mis_s && ld_fwd_s;
      drain_s     = (count_q != '0) && !ld_fwd_go_s;
      // The busy input is ignored in the first access cycle.
      done_s      = (state_q != IDLE) && !first_q && data_cache_blocking_n_i;
      deq_s       = (state_q == ST_ACC) && done_s;
   end

   // Access FSM, cache port image and load response
   always_comb begin
      state_d       = state_q;
      first_d       = 1'b0;
      cache_addr_d  = cache_addr_q;
      cache_we_d    = cache_we_q;
      cache_wdata_d = cache_wdata_q;
      cache_en_d    = cache_en_q;
      ld_off_d      = ld_off_q;
      ld_size_d     = ld_size_q;
      ld_uns_d      = ld_uns_q;
      ld_rd_d       = ld_rd_q;
      resp_valid_d  = 1'b0;
      resp_rd_d     = resp_rd_q;
      resp_data_d   = resp_data_q;
      misalign_d    = accept_s && req_mis_s;
      case (state_q)
         IDLE: begin
            if (ld_go_s) begin
               state_d       = LD_ACC;
               first_d       = 1'b1;
               cache_addr_d  = req_addr_i[31:2];
               cache_we_d    = 4'b0000;
               cache_wdata_d = 32'h0000_0000;
               cache_en_d    = 1'b1;
               ld_off_d      = req_addr_i[1:0];
               ld_size_d     = req_op_i[1:0];
               ld_uns_d      = req_op_i[2];
               ld_rd_d       = req_rd_i;
            end else if (drain_s) begin
               state_d       = ST_ACC;
               first_d       = 1'b1;
               cache_addr_d  = sb_addr_q[rd_ptr_q];
               cache_we_d    = sb_be_q[rd_ptr_q];
               cache_wdata_d = sb_data_q[rd_ptr_q];
               cache_en_d    = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         LD_ACC: begin
            if (done_s) begin
               state_d      = IDLE;
               cache_en_d   = 1'b0;
               resp_valid_d = 1'b1;
               resp_rd_d    = ld_rd_q;
               resp_data_d  = load_extend(data_cache_data_i, ld_off_q, ld_size_q, ld_uns_q);
            end else begin
               state_d = LD_ACC;
            end
         end
         ST_ACC: begin
            if (done_s) begin
               state_d    = IDLE;
               cache_en_d = 1'b0;
               cache_we_d = 4'b0000;
            end else begin
               state_d = ST_ACC;
            end
         end
         default: begin
            state_d    = IDLE;
            cache_en_d = 1'b0;
            cache_we_d = 4'b0000;
         end
      endcase
`ifdef LSU_STORE_FWD_EN
      // Forwarded loads only happen in IDLE, so they never collide with a cache response.
      if (ld_fwd_go_s) begin
         resp_valid_d = 1'b1;
         resp_rd_d    = req_rd_i;
         resp_data_d  = load_extend(hit_data_s, req_addr_i[1:0], req_op_i[1:0], req_op_i[2]);
      end else begin
         resp_valid_d = resp_valid_d;
      end
`endif
   end

   // Store buffer pointers and occupancy; the pointers wrap naturally at SB_DEPTH
   always_comb begin
      if (enq_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (deq_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({enq_s, deq_s})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase
      sb_empty_d = (count_d == '0);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         first_q       <= 1'b0;
         cache_addr_q  <= 30'h0000_0000;
         cache_we_q    <= 4'b0000;
         cache_wdata_q <= 32'h0000_0000;
         cache_en_q    <= 1'b0;
         ld_off_q      <= 2'b00;
         ld_size_q     <= 2'b00;
         ld_uns_q      <= 1'b0;
         ld_rd_q       <= 5'd0;
         resp_valid_q  <= 1'b0;
         resp_rd_q     <= 5'd0;
         resp_data_q   <= 32'h0000_0000;
         misalign_q    <= 1'b0;
         sb_empty_q    <= 1'b1;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         count_q       <= '0;
      end else begin
         state_q       <= state_d;
         first_q       <= first_d;
         cache_addr_q  <= cache_addr_d;
         cache_we_q    <= cache_we_d;
         cache_wdata_q <= cache_wdata_d;
         cache_en_q    <= cache_en_d;
         ld_off_q      <= ld_off_d;
         ld_size_q     <= ld_size_d;
         ld_uns_q      <= ld_uns_d;
         ld_rd_q       <= ld_rd_d;
         resp_valid_q  <= resp_valid_d;
         resp_rd_q     <= resp_rd_d;
         resp_data_q   <= resp_data_d;
         misalign_q    <= misalign_d;
         sb_empty_q    <= sb_empty_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         count_q       <= count_d;
      end
   end

   // Store buffer storage; contents need no reset because the pointers define validity
   always_ff @(posedge clk_i) begin
      if (enq_s && !rst_i) begin
         sb_addr_q[wr_ptr_q] <= req_addr_i[31:2];
         sb_be_q[wr_ptr_q]   <= st_be_s;
         sb_data_q[wr_ptr_q] <= st_data_s;
      end
   end

   assign resp_valid_o          = resp_valid_q;
   assign resp_rd_o             = resp_rd_q;
   assign resp_data_o           = resp_data_q;
   assign misalign_o            = misalign_q;
   assign sb_empty_o            = sb_empty_q;
   assign data_cache_address_o  = cache_addr_q;
   assign data_cache_write_en_o = cache_we_q;
   assign data_cache_data_o     = cache_wdata_q;
   assign data_cache_enabled_o  = cache_en_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter SB_DEPTH, default 4: store-buffer entries; SHALL be a power of two, 2..16.
REQ-002 clk_i  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_i  input  1  reset, synchronous and active-high.
REQ-004 req_valid_i  input  1  request present; req_ready_o  output  1  request accepted when both high at a rising edge.
REQ-005 req_op_i  input  4  {is_store, unsigned, size[1:0]}; size 00=byte, 01=half, 10=word, 11 reserved (treated as word).
REQ-006 req_addr_i  input  32  byte address; req_wdata_i  input  32  store data (LSBs); req_rd_i  input  5  load destination label.
REQ-007 resp_valid_o  output  1  one-cycle load completion; resp_rd_o  output  5; resp_data_o  output  32  extended load value.
REQ-008 misalign_o  output  1  one-cycle pulse for a rejected misaligned request.
REQ-009 sb_empty_o  output  1  store buffer empty and no store in flight.
REQ-010 data_cache_address_o  output  [31:2]; data_cache_write_en_o  output  4; data_cache_data_o  output  32; data_cache_enabled_o  output  1.
REQ-011 data_cache_data_i  input  32; data_cache_blocking_n_i  input  1  cache not busy.

Function
REQ-012 FSM states: IDLE, LD_ACC, ST_ACC; one cache access outstanding at any time.
REQ-013 Cache access: address, write_en, data and enabled=1 SHALL be held stable for every cycle of LD_ACC/ST_ACC; data_cache_blocking_n_i is ignored in the first access cycle; the access completes in the first later cycle with data_cache_blocking_n_i=1.
REQ-014 Minimum load latency: accept at edge E0 -> LD_ACC cycles C1, C2 (completion) -> resp_valid_o high in C3 only.
REQ-015 Load data: byte/half selected by addr[1:0]; sign-extended when unsigned=0, zero-extended when unsigned=1.
REQ-016 Store accept: ready when buffer not full (registered count), in any state; entry holds word address, 4-bit byte enable, lane-replicated data (SB: we=1<<addr[1:0]; SH: 0011 or 1100; SW: 1111).
REQ-017 Store accepted while full-and-dequeuing in the same cycle SHALL NOT occur (ready low when count==SB_DEPTH).
REQ-018 Load accept: ready only in IDLE and when no buffer entry (including one in ST_ACC) matches req_addr_i[31:2]; on mismatch the load goes to LD_ACC ahead of pending stores.
REQ-019 Drain: in IDLE with buffer non-empty and no acceptable load presented, head entry enters ST_ACC; popped on completion; FIFO order preserved.
REQ-020 Misaligned (half with addr[0]=1, word with addr[1:0]!=0): request consumed (ready high), misalign_o pulses next cycle, no cache access, no buffer entry, no resp_valid_o.
REQ-021 Count wrap: read/write pointers SHALL wrap modulo SB_DEPTH; simultaneous enqueue and dequeue leave count unchanged.

Reset
REQ-022 rst_i high at an edge: state IDLE, pointers and count 0, buffer contents discarded (stores lost), all outputs 0 except sb_empty_o=1, from the following cycle.
REQ-023 Reset during LD_ACC/ST_ACC abandons the access; data_cache_enabled_o low the next cycle; no response issued.

Configuration
REQ-024 Macro LSU_STORE_FWD_EN: when defined, a load whose youngest matching entry's byte enables cover all loaded bytes SHALL be accepted in IDLE and answered from the buffer with resp_valid_o one cycle after accept, no cache access; partial coverage falls back to REQ-018 stall.
REQ-025 Without LSU_STORE_FWD_EN, any address match stalls the load until the matching entries drain.

Verification
REQ-026 SW 0x100<-0xDEADBEEF, cache blocking_n 1 -> ST_ACC, write_en=1111, address[31:2]=0x40, sb_empty_o returns 1.
REQ-027 LB from 0x103 with word 0x80FF_0000 -> resp_data_o=0xFFFFFF80; LBU -> 0x00000080; LH 0x102 -> 0xFFFF80FF.
REQ-028 SH to 0x101 -> misalign_o pulse, ready high, no cache enable, buffer count unchanged.
REQ-029 Push 5 stores with SB_DEPTH=4 while cache blocking_n held 0 -> 5th ready low until first completion.
REQ-030 SW 0x200<-0x12345678 then LW 0x200: with macro resp 0x12345678 next cycle, no cache read; without macro load stalls until store completes, then reads cache.
REQ-031 rst_i asserted in second LD_ACC cycle -> enabled low next cycle, no resp_valid_o, sb_empty_o=1.
